decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file with writeback bypass, immediate generation, load-use stall.
// One cycle from accepted instruction to o_valid; holds its outputs while i_ex_ready is low.
module decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_FILE_DEPTH = 32,
    parameter int BYPASS_EN      = 1,
    localparam int REG_FILE_ADDR = $clog2(REG_FILE_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_instr,
    input  logic [DATA_WIDTH-1:0]    i_pc,
    input  logic                     i_wb_en,
    input  logic [REG_FILE_ADDR-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0]    i_wb_data,
    input  logic                     i_flush,
    input  logic                     i_ex_mem_read,
    input  logic [REG_FILE_ADDR-1:0] i_ex_rd,
    output logic                     o_valid,
    input  logic                     i_ex_ready,
    output logic [DATA_WIDTH-1:0]    o_data_1,
    output logic [DATA_WIDTH-1:0]    o_data_2,
    output logic [DATA_WIDTH-1:0]    o_imm,
    output logic [DATA_WIDTH-1:0]    o_pc,
    output logic [REG_FILE_ADDR-1:0] o_rs1,
    output logic [REG_FILE_ADDR-1:0] o_rs2,
    output logic [REG_FILE_ADDR-1:0] o_rd,
    output logic [6:0]               o_opcode,
    output logic [2:0]               o_funct3,
    output logic [6:0]               o_funct7,
    output logic                     o_illegal
);
    localparam logic [6:0] OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_REG = 7'b0110011;

    logic [DATA_WIDTH-1:0]    r_regs [REG_FILE_DEPTH];
    logic                     r_valid, r_illegal;
    logic [DATA_WIDTH-1:0]    r_data_1, r_data_2, r_imm, r_pc;
    logic [REG_FILE_ADDR-1:0] r_rs1, r_rs2, r_rd;
    logic [6:0]               r_opcode, r_funct7;
    logic [2:0]               r_funct3;

    logic [6:0]               w_opcode;
    logic [REG_FILE_ADDR-1:0] w_rs1, w_rs2, w_rd;
    logic [DATA_WIDTH-1:0]    w_src_1, w_src_2, w_imm;
    logic signed [31:0]       w_imm32;
    logic                     w_legal_op, w_is_uj, w_uses_rs2;
    logic                     w_hazard, w_load_en, w_wb_live;

    assign w_opcode = i_instr[6:0];
    assign w_rs1    = i_instr[15 +: REG_FILE_ADDR];
    assign w_rs2    = i_instr[20 +: REG_FILE_ADDR];
    assign w_rd     = i_instr[7 +: REG_FILE_ADDR];

    // A writeback landing this cycle is visible to the reader only when bypass is enabled.
    assign w_wb_live = (BYPASS_EN != 0) && i_wb_en && (i_wb_addr != '0);
    assign w_src_1 = (w_rs1 == '0) ? '0 : (w_wb_live && i_wb_addr == w_rs1) ? i_wb_data : r_regs[w_rs1];
    assign w_src_2 = (w_rs2 == '0) ? '0 : (w_wb_live && i_wb_addr == w_rs2) ? i_wb_data : r_regs[w_rs2];

    always_comb begin
        w_imm32    = '0;
        w_legal_op = 1'b1;
        w_is_uj    = 1'b0;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            OP_STORE: begin
                w_imm32    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                w_imm32    = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                w_uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {i_instr[31:12], 12'b0};
                w_is_uj = 1'b1;
            end
            OP_JAL: begin
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                w_is_uj = 1'b1;
            end
            OP_REG:  w_uses_rs2 = 1'b1;
            default: w_legal_op = 1'b0;
        endcase
    end

    // Size cast of a signed value sign-extends to the datapath width.
    assign w_imm = DATA_WIDTH'(w_imm32);

    assign w_hazard  = i_valid && i_ex_mem_read && (i_ex_rd != '0) && !w_is_uj &&
                       ((i_ex_rd == w_rs1) || (w_uses_rs2 && (i_ex_rd == w_rs2)));
    assign w_load_en = !r_valid || i_ex_ready;
    assign o_ready   = !i_reset && (i_flush || (w_load_en && !w_hazard));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REG_FILE_DEPTH; i++) r_regs[i] <= '0;
        end else if (i_wb_en && i_wb_addr != '0) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_data_1  <= '0;
            r_data_2  <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_load_en && w_hazard) begin
            r_valid <= 1'b0;
        end else if (w_load_en) begin
            r_valid   <= i_valid;
            r_illegal <= !w_legal_op || (i_instr[1:0] != 2'b11);
            r_data_1  <= w_src_1;
            r_data_2  <= w_src_2;
            r_imm     <= w_imm;
            r_pc      <= i_pc;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_opcode  <= w_opcode;
            r_funct3  <= i_instr[14:12];
            r_funct7  <= i_instr[31:25];
        end
    end

    assign o_valid   = r_valid;
    assign o_illegal = r_illegal;
    assign o_data_1  = r_data_1;
    assign o_data_2  = r_data_2;
    assign o_imm     = r_imm;
    assign o_pc      = r_pc;
    assign o_rs1     = r_rs1;
    assign o_rs2     = r_rs2;
    assign o_rd      = r_rd;
    assign o_opcode  = r_opcode;
    assign o_funct3  = r_funct3;
    assign o_funct7  = r_funct7;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against an instruction-level reference model.
module tb_decode_stage;
    localparam int DW = 32, DEPTH = 32, AW = 5, BYP = 1;

    logic          i_clk, i_reset, i_valid, o_ready;
    logic [31:0]   i_instr, i_pc;
    logic          i_wb_en;
    logic [AW-1:0] i_wb_addr;
    logic [DW-1:0] i_wb_data;
    logic          i_flush, i_ex_mem_read, i_ex_ready, o_valid, o_illegal;
    logic [AW-1:0] i_ex_rd, o_rs1, o_rs2, o_rd;
    logic [DW-1:0] o_data_1, o_data_2, o_imm, o_pc;
    logic [6:0]    o_opcode, o_funct7;
    logic [2:0]    o_funct3;

    decode_stage #(.DATA_WIDTH(DW), .REG_FILE_DEPTH(DEPTH), .BYPASS_EN(BYP)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .i_flush(i_flush), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_rd(i_ex_rd), .o_valid(o_valid), .i_ex_ready(i_ex_ready),
        .o_data_1(o_data_1), .o_data_2(o_data_2), .o_imm(o_imm), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_opcode(o_opcode),
        .o_funct3(o_funct3), .o_funct7(o_funct7), .o_illegal(o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0, fails = 0;

    // Reference model: architectural registers plus the instruction currently held downstream.
    logic [31:0] m_regs [32];
    bit          m_valid, m_ill;
    logic [31:0] m_instr, m_d1, m_d2, m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int v;
        v = 0;
        case (x[6:0])
            7'h13, 7'h03, 7'h67: v = (x[31] ? -2048 : 0) + int'(x[30:20]);
            7'h23: v = (x[31] ? -2048 : 0) + int'(x[30:25]) * 32 + int'(x[11:7]);
            7'h63: v = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
            7'h37, 7'h17: v = int'(x & 32'hFFFFF000);
            7'h6F: v = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048
                       + int'(x[30:21]) * 2;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit ref_legal(input logic [31:0] x);
        return (x[1:0] == 2'b11) && (x[6:0] inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                                    7'h37, 7'h17, 7'h6F, 7'h33});
    endfunction

    function automatic bit ref_hazard();
        bit uj, two;
        uj  = i_instr[6:0] inside {7'h37, 7'h17, 7'h6F};
        two = i_instr[6:0] inside {7'h33, 7'h23, 7'h63};
        return i_valid && i_ex_mem_read && (i_ex_rd != 0) && !uj &&
               ((i_ex_rd == i_instr[19:15]) || (two && i_ex_rd == i_instr[24:20]));
    endfunction

    function automatic bit ref_ready();
        return !i_reset && (i_flush || ((!m_valid || i_ex_ready) && !ref_hazard()));
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP != 0 && i_wb_en && i_wb_addr == a) return i_wb_data;
        return m_regs[a];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ill = 0; m_instr = 0; m_d1 = 0; m_d2 = 0; m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
    endtask

    task automatic model_edge();
        bit le;
        if (i_reset) begin
            model_reset();
        end else begin
            le = !m_valid || i_ex_ready;
            if (i_flush) m_valid = 0;
            else if (le && ref_hazard()) m_valid = 0;
            else if (le) begin
                m_valid = i_valid;
                m_instr = i_instr;
                m_ill   = !ref_legal(i_instr);
                m_d1    = ref_src(i_instr[19:15]);
                m_d2    = ref_src(i_instr[24:20]);
                m_pc    = i_pc;
            end
            if (i_wb_en && i_wb_addr != 0) m_regs[i_wb_addr] = i_wb_data;
        end
    endtask

    task automatic compare_outputs();
        check("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("o_data_1", o_data_1, m_d1);
            check("o_data_2", o_data_2, m_d2);
            check("o_imm", o_imm, ref_imm(m_instr));
            check("o_pc", o_pc, m_pc);
            check("o_rs1", {27'b0, o_rs1}, {27'b0, m_instr[19:15]});
            check("o_rs2", {27'b0, o_rs2}, {27'b0, m_instr[24:20]});
            check("o_rd", {27'b0, o_rd}, {27'b0, m_instr[11:7]});
            check("o_opcode", {25'b0, o_opcode}, {25'b0, m_instr[6:0]});
            check("o_funct3", {29'b0, o_funct3}, {29'b0, m_instr[14:12]});
            check("o_funct7", {25'b0, o_funct7}, {25'b0, m_instr[31:25]});
            check("o_illegal", {31'b0, o_illegal}, {31'b0, m_ill});
        end
    endtask

    // One clock: ready checked mid-cycle, model advanced on the edge, outputs checked just after.
    task automatic cyc();
        @(negedge i_clk);
        check("o_ready", {31'b0, o_ready}, {31'b0, ref_ready()});
        @(posedge i_clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        i_valid = 0; i_instr = 32'h13; i_pc = 0; i_wb_en = 0; i_wb_addr = 0; i_wb_data = 0;
        i_flush = 0; i_ex_mem_read = 0; i_ex_rd = 0; i_ex_ready = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'b0, o_valid}, 32'h0);
        check({tag, "_ready"}, {31'b0, o_ready}, 32'h0);
        check({tag, "_data_1"}, o_data_1, 32'h0);
        check({tag, "_imm"}, o_imm, 32'h0);
        check({tag, "_pc"}, o_pc, 32'h0);
        check({tag, "_rd"}, {27'b0, o_rd}, 32'h0);
        check({tag, "_illegal"}, {31'b0, o_illegal}, 32'h0);
    endtask

    initial begin
        idle();
        i_reset = 1;
        model_reset();
        #2;
        check_all_zero("reset");
        cyc();
        i_reset = 0;

        // Register write then ADDI x6,x5,-1
        i_wb_en = 1; i_wb_addr = 5; i_wb_data = 32'h1234;
        cyc();
        idle();
        i_valid = 1; i_instr = 32'hFFF28313; i_pc = 32'h100;
        cyc();
        check("addi_valid", {31'b0, o_valid}, 32'h1);
        check("addi_data_1", o_data_1, 32'h1234);
        check("addi_imm", o_imm, 32'hFFFFFFFF);
        check("addi_rd", {27'b0, o_rd}, 32'd6);

        // SW x7,0(x2) with same-cycle writeback of x7
        i_instr = 32'h00712023;
        i_wb_en = 1; i_wb_addr = 7; i_wb_data = 32'hA5A5A5A5;
        cyc();
        check("sw_bypass_data_2", o_data_2, 32'hA5A5A5A5);
        idle();

        // ADD x4,x3,x1 behind a load to x3
        i_valid = 1; i_instr = 32'h00118233; i_ex_mem_read = 1; i_ex_rd = 3;
        #1;
        check("hazard_ready", {31'b0, o_ready}, 32'h0);
        cyc();
        check("hazard_bubble", {31'b0, o_valid}, 32'h0);
        i_ex_mem_read = 0;
        cyc();
        check("hazard_issue_valid", {31'b0, o_valid}, 32'h1);
        check("hazard_issue_rd", {27'b0, o_rd}, 32'd4);

        // Downstream stall with a writeback targeting the held source
        i_ex_ready = 0; i_instr = 32'hFFF28313;
        i_wb_en = 1; i_wb_addr = 3; i_wb_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            i_wb_en = 0;
            check("stall_ready", {31'b0, o_ready}, 32'h0);
            check("stall_rd", {27'b0, o_rd}, 32'd4);
            check("stall_data_1", o_data_1, 32'h0);
        end
        i_ex_ready = 1;
        cyc();
        check("stall_release_rd", {27'b0, o_rd}, 32'd6);

        // BEQ x0,x0,+8 then flush
        i_instr = 32'h00000463;
        cyc();
        check("beq_imm", o_imm, 32'h8);
        i_flush = 1; i_instr = 32'h004000EF;
        cyc();
        check("flush_valid", {31'b0, o_valid}, 32'h0);
        i_flush = 0;
        cyc();
        // This encoding is jal ra,+4
        check("jal_imm", o_imm, 32'h4);
        check("jal_rd", {27'b0, o_rd}, 32'd1);
        i_instr = 32'h0000007F;
        cyc();
        check("illegal_7f", {31'b0, o_illegal}, 32'h1);

        // Flush, hazard and ready together: flush wins
        i_instr = 32'h00118233; i_ex_mem_read = 1; i_ex_rd = 1; i_flush = 1;
        #1;
        check("flush_ready", {31'b0, o_ready}, 32'h1);
        cyc();
        check("flush_over_hazard", {31'b0, o_valid}, 32'h0);
        idle();

        // Writes to x0 are dropped, bypass included
        i_wb_en = 1; i_wb_addr = 0; i_wb_data = 32'hFFFFFFFF;
        i_valid = 1; i_instr = 32'h00000093;
        cyc();
        check("x0_bypass", o_data_1, 32'h0);
        i_wb_en = 0;
        cyc();
        check("x0_read", o_data_1, 32'h0);

        // Reset while stalled: outputs clear at once and the held instruction is lost
        i_ex_ready = 0;
        cyc();
        i_reset = 1;
        #1;
        check_all_zero("midreset");
        model_reset();
        cyc();
        i_reset = 0;
        idle();
        cyc();
        check("post_reset_valid", {31'b0, o_valid}, 32'h0);
        i_valid = 1; i_instr = 32'hFFF28313;
        cyc();
        check("post_reset_x5", o_data_1, 32'h0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [6:0] ops [11];
            logic [31:0] ins;
            ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 19) == 0) ins[1:0] = 2'($urandom_range(0, 2));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            i_instr       = ins;
            i_pc          = $urandom;
            i_valid       = ($urandom_range(0, 9) < 7);
            i_ex_ready    = ($urandom_range(0, 9) < 7);
            i_flush       = ($urandom_range(0, 19) == 0);
            i_ex_mem_read = ($urandom_range(0, 9) < 3);
            i_ex_rd       = 5'($urandom_range(0, 7));
            i_wb_en       = $urandom_range(0, 1) == 1;
            i_wb_addr     = 5'($urandom_range(0, 7));
            i_wb_data     = $urandom;
            i_reset       = ($urandom_range(0, 199) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
